// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, accumulator sizing and FSM states for the FIR chain
package fir_pkg;

    localparam int BW_IN_DEF  = 8;
    localparam int BW_OUT_DEF = 8;

    // Accumulator width that cannot overflow when summing decim samples of bw_in bits
    function automatic int acc_w(input int bw_in, input int decim);
        return bw_in + $clog2(decim);
    endfunction

    typedef enum logic [0:0] {
        ST_SKIP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fir_decimator_if.sv
// rtl/fir_decimator_if.sv - sample-in / result-out bundle of the FIR decimator
interface fir_decimator_if import fir_pkg::*; #(
    parameter int BW_in  = BW_IN_DEF,
    parameter int BW_out = BW_OUT_DEF
) ();

    logic                     in_valid;
    logic signed [BW_in-1:0]  y_in;
    logic                     out_valid;
    logic signed [BW_out-1:0] y_out;
    logic                     sat_flag;

    modport master (
        output in_valid, y_in,
        input  out_valid, y_out, sat_flag
    );

    modport slave (
        input  in_valid, y_in,
        output out_valid, y_out, sat_flag
    );

endinterface

// File: rtl/fir_saturate.sv
// rtl/fir_saturate.sv - combinational signed clip from IN_W to OUT_W bits with a saturation bit
module fir_saturate #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 8
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam int TOP_W = IN_W - OUT_W + 1;

    // The value fits only when the bits above the output sign bit all copy it
    logic [TOP_W-1:0] top_bits;
    assign top_bits = din[IN_W-1:OUT_W-1];

    // Clip to the most positive or most negative output code when it does not fit
    always_comb begin
        sat  = 1'b0;
        dout = din[OUT_W-1:0];
        if (!((top_bits == '0) || (top_bits == '1))) begin
            sat  = 1'b1;
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - integrate-and-dump decimator with shift and saturation (FIR_DECIM_ROUND_EN selects round-half-up)
module fir_decimator import fir_pkg::*; #(
    parameter int BW_in        = BW_IN_DEF,
    parameter int DECIM        = 4,
    parameter int SHIFT        = 2,
    parameter int BW_out       = BW_OUT_DEF,
    parameter int SKIP_SAMPLES = 1
) (
    input  logic          clk,
    input  logic          reset,
    fir_decimator_if.slave bus
);

    localparam int ACC_W  = acc_w(BW_in, DECIM);
    localparam int CNT_W  = $clog2(DECIM);
    localparam int SKIP_W = 4;
`ifdef FIR_DECIM_ROUND_EN
    localparam int SH_W   = ACC_W + 1;
`else
    localparam int SH_W   = ACC_W;
`endif

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DECIM - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST   = SKIP_W'(SKIP_SAMPLES - 1);
    localparam state_e            RESET_STATE = (SKIP_SAMPLES == 0) ? ST_RUN : ST_SKIP;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [SKIP_W-1:0]        skip_q, skip_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [BW_out-1:0] y_out_q, y_out_d;
    logic                     sat_flag_q, sat_flag_d;

    logic signed [ACC_W-1:0]  y_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [SH_W-1:0]   pre_shift;
    logic signed [SH_W-1:0]   shifted;
    logic signed [BW_out-1:0] sat_val;
    logic                     sat_bit;

    assign y_ext = {{(ACC_W-BW_in){bus.y_in[BW_in-1]}}, bus.y_in};

    // Window total including the sample arriving this cycle, then scaling
    always_comb begin
        sum = acc_q + y_ext;
`ifdef FIR_DECIM_ROUND_EN
        if (SHIFT > 0) begin
            pre_shift = {sum[ACC_W-1], sum} + (SH_W'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0));
        end else begin
            pre_shift = {sum[ACC_W-1], sum};
        end
`else
        pre_shift = sum;
`endif
        shifted = pre_shift >>> SHIFT;
    end

    fir_saturate #(
        .IN_W  (SH_W),
        .OUT_W (BW_out)
    ) u_sat (
        .din  (shifted),
        .dout (sat_val),
        .sat  (sat_bit)
    );

    // Skip/run sequencing, window accumulation and dump on the last sample
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        skip_d      = skip_q;
        out_valid_d = 1'b0;
        y_out_d     = y_out_q;
        sat_flag_d  = sat_flag_q;
        if (bus.in_valid) begin
            case (state_q)
                ST_SKIP: begin
                    skip_d = skip_q + 1'b1;
                    if (skip_q == SKIP_LAST) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_LAST) begin
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b1;
                        y_out_d     = sat_val;
                        if (sat_bit) begin
                            sat_flag_d = 1'b1;
                        end
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RESET_STATE;
                end
            endcase
        end
    end

    // State registers with immediate reset that also abandons any open window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            acc_q       <= '0;
            cnt_q       <= '0;
            skip_q      <= '0;
            out_valid_q <= 1'b0;
            y_out_q     <= '0;
            sat_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            out_valid_q <= out_valid_d;
            y_out_q     <= y_out_d;
            sat_flag_q  <= sat_flag_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.y_out     = y_out_q;
    assign bus.sat_flag  = sat_flag_q;

endmodule
